csi_rx_packet_ctrl: RTL and testbench
=====================================

// Module: csi_rx_packet_ctrl
// PURPOSE
//  Sequences the CSI-2 RX payload path between the lane word aligner and the 10-bit unpacker.
//  - Decodes each packet header and generates frame/line sync.
//  - Gates RAW10 long-packet payload words into the unpacker and holds its enable.
//  - Drops CRC, unsupported long packets and malformed packets.
// PARAMETERS
//  RAW10_DT   8'h2B    data type forwarded to the unpacker
//  MAX_WC     16'd4000 largest legal word count (bytes)
// PORTS
//  clock          in   1   byte-clock domain clock
//  reset_n        in   1   asynchronous, active-low reset
//  data_in        in   32  aligned packet word, byte0 = [7:0]
//  din_valid      in   1   word valid; low between HS bursts (one packet per burst)
//  pix_word       out  32  payload word to unpacker data_in
//  pix_valid      out  1   payload word valid (unpacker din_valid)
//  unpack_enable  out  1   unpacker enable
//  frame_start    out  1   1-cycle pulse on FS short packet (DT 8'h00)
//  frame_end      out  1   1-cycle pulse on FE short packet (DT 8'h01)
//  line_start     out  1   1-cycle pulse on first payload word of a RAW10 line
//  line_end       out  1   1-cycle pulse with last payload word of a RAW10 line
//  frame_active   out  1   set by FS, cleared by FE
//  vc             out  2   virtual channel of the last accepted header (DI[7:6])
//  pkt_error      out  1   1-cycle pulse on any packet abort or reject
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word counter 0. Reset mid-packet aborts with no pulses.
//  Header word: DI = [7:0] (DT = DI[5:0], VC = DI[7:6]); WC = [23:8]; ECC = [31:24].
//  States:
//   - IDLE: first din_valid word is the header; decode it in the same cycle.
//     - DT<8'h10 (short packet): FS/FE pulse the next cycle; other short DTs ignored. -> WAIT_EOT.
//     - DT==RAW10_DT with WC!=0, WC[1:0]==0 and WC<=MAX_WC: load rem = WC>>2. -> PAYLOAD.
//     - DT==RAW10_DT violating any of the above: pkt_error pulse. -> WAIT_EOT.
//     - Any other long DT: -> WAIT_EOT, silently skipped.
//   - PAYLOAD: each din_valid word is registered to pix_word with pix_valid=1 (latency 1 clk); rem decrements.
//     - line_start accompanies the first forwarded word; line_end accompanies the word where rem hits 0. -> WAIT_EOT.
//     - din_valid low while rem!=0: pkt_error pulse, no line_end. -> IDLE.
//   - WAIT_EOT: discard words (CRC, trailing bytes, skipped payload); din_valid low -> IDLE.
//  Gating: pix_valid is never high outside PAYLOAD forwarding.
//  unpack_enable: 1 from PAYLOAD entry until 4 clocks after the last pix_valid, so the unpacker's 3-stage pipe drains; otherwise 0.
//  frame_active: FS while already active raises pkt_error and stays 1; FE while inactive raises pkt_error only.
//  Header in the same cycle as the preceding packet's last WAIT_EOT word: impossible by protocol, since din_valid must drop between bursts.
//  Pulses never overlap: at most one of frame_start/frame_end/line_start per clock. line_start and line_end coincide when WC==4.
// CONFIGURATION
//  CSI_RX_PKT_ECC_CHECK_EN
//   - Defined: compute the CSI-2 6-bit Hamming ECC over header bytes 0..2 (combinational, same cycle) and compare with ECC[5:0].
//     - On mismatch: pkt_error pulse, no sync pulses, no payload. -> WAIT_EOT.
//     - No single-bit correction.
//   - Not defined: ECC byte ignored; all headers trusted.
// TESTING
//  1. Header 32'h??_0000_00 (FS, VC0) then din_valid low -> frame_start 1 clk, frame_active=1, vc=0.
//  2. FS; RAW10 header WC=16'd20 + 5 payload words + 1 CRC word -> 5 pix_valid (1-clk latency), line_start on 1st, line_end on 5th; CRC word not forwarded; unpack_enable drops 4 clks after 5th word.
//  3. RAW10 WC=16'd22 (not multiple of 4) -> pkt_error pulse, no pix_valid; next FE packet still gives frame_end.
//  4. RAW10 WC=20, din_valid drops after 3 payload words -> pkt_error, 3 pix_valid, no line_end; next header decoded normally.
//  5. Long DT 8'h12 WC=8 + 3 words -> nothing forwarded, no pulses; FE while frame_active=0 -> pkt_error.
//  6. ECC_EN build: FS header with ECC bit 0 flipped -> pkt_error, no frame_start; correct ECC -> frame_start.
//     Non-ECC build: same flipped header -> frame_start.

Source files
------------

// File: rtl/csi_rx_packet_ctrl.sv
// CSI-2 RX packet sequencer: decodes headers, generates frame/line sync and gates RAW10 payload
// into the 10-bit unpacker. Optional header ECC check: define CSI_RX_PKT_ECC_CHECK_EN.
module csi_rx_packet_ctrl #(
   parameter logic [7:0]  RAW10_DT = 8'h2B,
   parameter logic [15:0] MAX_WC   = 16'd4000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_in,
   input  logic        din_valid,
   output logic [31:0] pix_word,
   output logic        pix_valid,
   output logic        unpack_enable,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic        frame_active,
   output logic [1:0]  vc,
   output logic        pkt_error
);

   typedef enum logic [1:0] {StIdle, StPayload, StWaitEot} state_e;

   state_e      state_q;
   logic [31:0] pix_word_q;
   logic        pix_valid_q, en_q, fs_q, fe_q, ls_q, le_q, active_q, err_q, first_q;
   logic [1:0]  vc_q;
   logic [13:0] rem_q;
   logic [2:0]  drain_q;

   logic [5:0]  hdr_dt;
   logic [1:0]  hdr_vc;
   logic [15:0] hdr_wc;
   logic        is_short, is_raw10, wc_ok, ecc_ok;

   assign hdr_dt   = data_in[5:0];
   assign hdr_vc   = data_in[7:6];
   assign hdr_wc   = data_in[23:8];
   assign is_short = (hdr_dt < 6'h10);
   assign is_raw10 = ({2'b00, hdr_dt} == RAW10_DT);
   assign wc_ok    = (hdr_wc != 16'd0) && (hdr_wc[1:0] == 2'b00) && (hdr_wc <= MAX_WC);

`ifdef CSI_RX_PKT_ECC_CHECK_EN
   logic [5:0] ecc_calc;
   logic       unused_ecc_hi;
   // Each parity bit covers a fixed subset of the 24 header bits.
   always_comb begin
      ecc_calc[0] = ^(data_in[23:0] & 24'hF12CB7);
      ecc_calc[1] = ^(data_in[23:0] & 24'hF2555B);
      ecc_calc[2] = ^(data_in[23:0] & 24'h749A6D);
      ecc_calc[3] = ^(data_in[23:0] & 24'hB8E38E);
      ecc_calc[4] = ^(data_in[23:0] & 24'hDF03F0);
      ecc_calc[5] = ^(data_in[23:0] & 24'hEFFC00);
   end
   assign ecc_ok        = (ecc_calc == data_in[29:24]);
   assign unused_ecc_hi = ^data_in[31:30];
`else
   logic unused_ecc;
   assign ecc_ok     = 1'b1;
   assign unused_ecc = ^data_in[31:24];
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         pix_word_q  <= 32'd0;
         pix_valid_q <= 1'b0;
         en_q        <= 1'b0;
         fs_q        <= 1'b0;
         fe_q        <= 1'b0;
         ls_q        <= 1'b0;
         le_q        <= 1'b0;
         active_q    <= 1'b0;
         err_q       <= 1'b0;
         first_q     <= 1'b0;
         vc_q        <= 2'b00;
         rem_q       <= 14'd0;
         drain_q     <= 3'd0;
      end else begin
         pix_valid_q <= 1'b0;
         fs_q        <= 1'b0;
         fe_q        <= 1'b0;
         ls_q        <= 1'b0;
         le_q        <= 1'b0;
         err_q       <= 1'b0;
         // Hold the unpacker enabled while its pipeline drains after the last word.
         if (drain_q != 3'd0) begin
            drain_q <= drain_q - 3'd1;
            if (drain_q == 3'd1) en_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (din_valid) begin
                  state_q <= StWaitEot;
                  if (!ecc_ok) begin
                     err_q <= 1'b1;
                  end else begin
                     vc_q <= hdr_vc;
                     if (is_short) begin
                        if (hdr_dt == 6'h00) begin
                           fs_q     <= 1'b1;
                           err_q    <= active_q;
                           active_q <= 1'b1;
                        end else if (hdr_dt == 6'h01) begin
                           fe_q     <= active_q;
                           err_q    <= ~active_q;
                           active_q <= 1'b0;
                        end
                     end else if (is_raw10 && wc_ok) begin
                        rem_q   <= hdr_wc[15:2];
                        first_q <= 1'b1;
                        en_q    <= 1'b1;
                        drain_q <= 3'd0;
                        state_q <= StPayload;
                     end else if (is_raw10) begin
                        err_q <= 1'b1;
                     end
                  end
               end
            end
            StPayload: begin
               if (din_valid) begin
                  pix_word_q  <= data_in;
                  pix_valid_q <= 1'b1;
                  ls_q        <= first_q;
                  first_q     <= 1'b0;
                  rem_q       <= rem_q - 14'd1;
                  if (rem_q == 14'd1) begin
                     le_q    <= 1'b1;
                     drain_q <= 3'd4;
                     state_q <= StWaitEot;
                  end
               end else begin
                  // Burst ended early: the last forwarded word was one clock ago.
                  err_q   <= 1'b1;
                  drain_q <= 3'd3;
                  first_q <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StWaitEot: begin
               if (!din_valid) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign pix_word      = pix_word_q;
   assign pix_valid     = pix_valid_q;
   assign unpack_enable = en_q;
   assign frame_start   = fs_q;
   assign frame_end     = fe_q;
   assign line_start    = ls_q;
   assign line_end      = le_q;
   assign frame_active  = active_q;
   assign vc            = vc_q;
   assign pkt_error     = err_q;

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Directed bench for csi_rx_packet_ctrl; expectations follow CSI_RX_PKT_ECC_CHECK_EN when defined.
module tb_csi_rx_packet_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] data_in;
   logic        din_valid;
   logic [31:0] pix_word;
   logic        pix_valid, unpack_enable, frame_start, frame_end;
   logic        line_start, line_end, frame_active, pkt_error;
   logic [1:0]  vc;

   csi_rx_packet_ctrl dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .data_in       (data_in),
      .din_valid     (din_valid),
      .pix_word      (pix_word),
      .pix_valid     (pix_valid),
      .unpack_enable (unpack_enable),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .line_start    (line_start),
      .line_end      (line_end),
      .frame_active  (frame_active),
      .vc            (vc),
      .pkt_error     (pkt_error)
   );

   always #5 clock = ~clock;

   // Headers with hand-computed ECC bytes.
   localparam logic [31:0] HdrFs0    = 32'h0000_0000;
   localparam logic [31:0] HdrFs0Bad = 32'h0100_0000;
   localparam logic [31:0] HdrFs1    = 32'h1600_0040;
   localparam logic [31:0] HdrFe0    = 32'h0700_0001;
   localparam logic [31:0] HdrRaw20  = 32'h1200_142B;
   localparam logic [31:0] HdrRaw22  = 32'h0E00_162B;
   localparam logic [31:0] HdrRaw4   = 32'h3400_042B;
   localparam logic [31:0] HdrRaw0   = 32'h1700_002B;
   localparam logic [31:0] HdrDt12   = 32'h3D00_0812;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt      = 0;
   int drv_cyc  = 0;

   // Monitor state, written only by the monitor.
   int          n_pix = 0, n_ls = 0, n_le = 0, n_fs = 0, n_fe = 0, n_err = 0, n_overlap = 0;
   int          pix_rise_cyc = -1, last_pix_cyc = -1, ls_cyc = -1, le_cyc = -1, fs_cyc = -1;
   int          en_rise_cyc = -1, en_fall_cyc = -1;
   logic        pix_prev = 1'b0, en_prev = 1'b0;
   logic [31:0] obs_w [0:63];

   int b_pix, b_ls, b_le, b_fs, b_fe, b_err;

   always @(posedge clock) cnt <= cnt + 1;

   always @(negedge clock) begin
      if (reset_n) begin
         if (pix_valid) begin
            if (!pix_prev) pix_rise_cyc = cnt;
            last_pix_cyc = cnt;
            obs_w[n_pix % 64] = pix_word;
            n_pix++;
         end
         if (line_start) begin n_ls++; ls_cyc = cnt; end
         if (line_end) begin n_le++; le_cyc = cnt; end
         if (frame_start) begin n_fs++; fs_cyc = cnt; end
         if (frame_end) n_fe++;
         if (pkt_error) n_err++;
         if (int'(frame_start) + int'(frame_end) + int'(line_start) > 1) n_overlap++;
         if (unpack_enable && !en_prev) en_rise_cyc = cnt;
         if (!unpack_enable && en_prev) en_fall_cyc = cnt;
         pix_prev = pix_valid;
         en_prev  = unpack_enable;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      @(posedge clock);
      #1;
      din_valid = 1'b1;
      data_in   = w;
      drv_cyc   = cnt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         din_valid = 1'b0;
         data_in   = 32'd0;
      end
   endtask

   task automatic snap;
      b_pix = n_pix; b_ls = n_ls; b_le = n_le; b_fs = n_fs; b_fe = n_fe; b_err = n_err;
   endtask

   int hc, w5, fs_drv;

   initial begin
      reset_n   = 1'b0;
      din_valid = 1'b0;
      data_in   = 32'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("reset_ctl", {22'd0, pix_valid, unpack_enable, frame_start, frame_end, line_start,
                             line_end, frame_active, vc, pkt_error}, 32'd0);
      check_eq("reset_pix_word", pix_word, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(2);

      // FS on VC0
      snap();
      push(HdrFs0);
      fs_drv = drv_cyc;
      idle(4);
      check_eq("t1_fs_count", n_fs - b_fs, 1);
      check_eq("t1_fs_latency", fs_cyc - fs_drv, 1);
      check_eq("t1_frame_active", frame_active, 1);
      check_eq("t1_vc", vc, 0);
      check_eq("t1_err", n_err - b_err, 0);

      // RAW10 line, WC=20: five words plus CRC
      snap();
      push(HdrRaw20);
      hc = drv_cyc;
      for (int i = 0; i < 5; i++) push(32'hA5A5_0000 + i);
      w5 = drv_cyc;
      push(32'hDEAD_BEEF);
      idle(8);
      check_eq("t2_pix_count", n_pix - b_pix, 5);
      for (int i = 0; i < 5; i++) check_eq("t2_pix_word", obs_w[(b_pix + i) % 64], 32'hA5A5_0000 + i);
      check_eq("t2_first_latency", pix_rise_cyc - hc, 2);
      check_eq("t2_last_latency", last_pix_cyc - w5, 1);
      check_eq("t2_ls_count", n_ls - b_ls, 1);
      check_eq("t2_ls_on_first", ls_cyc, pix_rise_cyc);
      check_eq("t2_le_count", n_le - b_le, 1);
      check_eq("t2_le_on_last", le_cyc, last_pix_cyc);
      check_eq("t2_en_rise", en_rise_cyc - hc, 1);
      check_eq("t2_en_drain", en_fall_cyc - last_pix_cyc, 4);
      check_eq("t2_err", n_err - b_err, 0);

      // WC not a multiple of 4, then FE still honoured
      snap();
      push(HdrRaw22);
      for (int i = 0; i < 6; i++) push(32'h1234_0000 + i);
      idle(3);
      check_eq("t3_err", n_err - b_err, 1);
      check_eq("t3_pix_count", n_pix - b_pix, 0);
      check_eq("t3_en", unpack_enable, 0);
      snap();
      push(HdrFe0);
      idle(3);
      check_eq("t3_fe_count", n_fe - b_fe, 1);
      check_eq("t3_frame_active", frame_active, 0);
      check_eq("t3_fe_err", n_err - b_err, 0);

      // Burst drops after 3 of 5 payload words
      snap();
      push(HdrRaw20);
      for (int i = 0; i < 3; i++) push(32'h0BAD_0000 + i);
      idle(8);
      check_eq("t4_pix_count", n_pix - b_pix, 3);
      check_eq("t4_err", n_err - b_err, 1);
      check_eq("t4_le_count", n_le - b_le, 0);
      check_eq("t4_ls_count", n_ls - b_ls, 1);
      check_eq("t4_en_off", unpack_enable, 0);
      snap();
      push(HdrFs1);
      idle(3);
      check_eq("t4_next_fs", n_fs - b_fs, 1);
      check_eq("t4_next_vc", vc, 1);
      check_eq("t4_next_err", n_err - b_err, 0);

      // Unsupported long DT is skipped silently
      snap();
      push(HdrDt12);
      for (int i = 0; i < 3; i++) push(32'h5555_0000 + i);
      idle(3);
      check_eq("t5_pix_count", n_pix - b_pix, 0);
      check_eq("t5_pulses", (n_fs - b_fs) + (n_fe - b_fe) + (n_ls - b_ls) + (n_le - b_le)
                            + (n_err - b_err), 0);
      check_eq("t5_vc", vc, 0);
      push(HdrFe0);
      idle(3);
      check_eq("t5_frame_closed", frame_active, 0);
      snap();
      push(HdrFe0);
      idle(3);
      check_eq("t5_fe_inactive_err", n_err - b_err, 1);
      check_eq("t5_fe_inactive_fe", n_fe - b_fe, 0);

      // WC=4: line_start and line_end on the same word
      snap();
      push(HdrRaw4);
      push(32'hCAFE_F00D);
      push(32'h0000_1111);
      idle(6);
      check_eq("wc4_pix_count", n_pix - b_pix, 1);
      check_eq("wc4_pix_word", obs_w[b_pix % 64], 32'hCAFE_F00D);
      check_eq("wc4_ls_le_same", ls_cyc, le_cyc);
      check_eq("wc4_le_count", n_le - b_le, 1);

      // WC=0 rejected
      snap();
      push(HdrRaw0);
      push(32'h0000_2222);
      idle(3);
      check_eq("wc0_err", n_err - b_err, 1);
      check_eq("wc0_pix_count", n_pix - b_pix, 0);

      // FS header with ECC bit 0 flipped
      snap();
      push(HdrFs0Bad);
      idle(3);
`ifdef CSI_RX_PKT_ECC_CHECK_EN
      check_eq("t6_bad_ecc_err", n_err - b_err, 1);
      check_eq("t6_bad_ecc_fs", n_fs - b_fs, 0);
      snap();
      push(HdrFs0);
      idle(3);
      check_eq("t6_good_ecc_fs", n_fs - b_fs, 1);
      check_eq("t6_good_ecc_err", n_err - b_err, 0);
`else
      check_eq("t6_no_ecc_fs", n_fs - b_fs, 1);
      check_eq("t6_no_ecc_err", n_err - b_err, 0);
`endif

      check_eq("pulse_overlap", n_overlap, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
